prog_counter: RTL and testbench

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/prog_counter_pkg.sv | 25 ++
 rtl/tick_divider.sv | 29 ++
 rtl/prog_counter.sv | 123 ++++++++++++
 tb/tb_prog_counter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_counter_pkg.sv
// Shared types for prog_counter: terminal-behaviour modes, FSM states and mode decoding.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_WRAP   = 2'b01,
    MODE_BOUNCE = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_UP   = 2'b00,
    ST_DOWN = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // The unused encoding 2'b11 behaves as HOLD.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   decode_mode = MODE_WRAP;
      2'b10:   decode_mode = MODE_BOUNCE;
      default: decode_mode = MODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Emits a one-cycle tick on every PRESCALE-th enabled cycle; i_clear restarts the count.
module tick_divider
  import prog_counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_reg;

  assign o_tick = i_enable && (count_reg == LAST);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_clear) begin
      count_reg <= '0;
    end else if (i_enable) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with HOLD/WRAP/BOUNCE terminal behaviour.
// Optional advance prescaler is compiled in when PROG_COUNTER_PRESCALE_EN is defined.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int STEP     = 1,
  parameter int PRESCALE = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic [WIDTH-1:0] i_top,
  input  logic [1:0]       i_mode,
  input  logic             i_restart,
  output logic [WIDTH-1:0] o_value,
  output logic             o_hit_top,
  output logic             o_done,
  output logic             o_dir
);

  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

  state_e           state_reg, state_next;
  logic [WIDTH-1:0] value_reg, value_next;
  logic             hit_reg, hit_next;
  logic             advance;
  logic [WIDTH:0]   sum_up;
  logic             at_or_past_top;
  logic             reaches_top;
  mode_e            mode;

`ifdef PROG_COUNTER_PRESCALE_EN
  logic tick;
  logic presc_clear;

  assign presc_clear = i_load | (i_enable & i_restart);

  tick_divider #(
    .PRESCALE(PRESCALE)
  ) u_tick_divider (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_clear  (presc_clear),
    .i_enable (i_enable),
    .o_tick   (tick)
  );

  assign advance = i_enable & tick;
`else
  assign advance = i_enable;
`endif

  // Extra bit keeps value + STEP from wrapping before it is compared with top.
  assign sum_up         = {1'b0, value_reg} + STEP_EXT;
  assign at_or_past_top = value_reg >= i_top;
  assign reaches_top    = sum_up >= {1'b0, i_top};
  assign mode           = decode_mode(i_mode);

  always_comb begin
    state_next = state_reg;
    value_next = value_reg;
    hit_next   = 1'b0;
    if (i_load) begin
      value_next = (i_load_value > i_top) ? i_top : i_load_value;
      state_next = ST_UP;
    end else if (i_enable && i_restart) begin
      value_next = '0;
      state_next = ST_UP;
    end else if (advance) begin
      case (state_reg)
        ST_UP: begin
          // WRAP parks on top for one advance; a top lowered below the count wraps at once and pulses.
          if (mode == MODE_WRAP && at_or_past_top) begin
            value_next = '0;
            hit_next   = (value_reg != i_top) || (i_top == '0);
          end else if (reaches_top) begin
            value_next = i_top;
            hit_next   = 1'b1;
            if (mode == MODE_HOLD) begin
              state_next = ST_DONE;
            end else if (mode == MODE_BOUNCE) begin
              state_next = ST_DOWN;
            end
          end else begin
            value_next = sum_up[WIDTH-1:0];
          end
        end
        ST_DOWN: begin
          if (value_reg > STEP_W) begin
            value_next = value_reg - STEP_W;
          end else begin
            value_next = '0;
            state_next = ST_UP;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_reg <= ST_UP;
      value_reg <= '0;
      hit_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      value_reg <= value_next;
      hit_reg   <= hit_next;
    end
  end

  assign o_value   = value_reg;
  assign o_hit_top = hit_reg;
  assign o_done    = (state_reg == ST_DONE);
  assign o_dir     = (state_reg == ST_DOWN);

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: a driver pushes reference-model results, a monitor compares.
module tb_prog_counter;

  localparam int WIDTH    = 6;
  localparam int STEP     = 3;
  localparam int PRESCALE = 3;
  localparam int PH_UP    = 0;
  localparam int PH_DOWN  = 1;
  localparam int PH_DONE  = 2;

  typedef struct {
    int value;
    bit hit;
    bit done;
    bit dir;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] top;
  logic [1:0]       mode;
  logic             restart;
  logic [WIDTH-1:0] value;
  logic             hit_top;
  logic             done;
  logic             dir;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  // Reference model state: count, phase, pulse, enabled cycles since last prescale clear.
  int mv  = 0;
  int mph = PH_UP;
  bit mhit = 0;
  int mpc = 0;

  prog_counter #(
    .WIDTH   (WIDTH),
    .STEP    (STEP),
    .PRESCALE(PRESCALE)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_enable    (enable),
    .i_load      (load),
    .i_load_value(load_value),
    .i_top       (top),
    .i_mode      (mode),
    .i_restart   (restart),
    .o_value     (value),
    .o_hit_top   (hit_top),
    .o_done      (done),
    .o_dir       (dir)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_step();
    int  tp;
    int  sum;
    bit  adv;
    tp = int'(top);
    if (!rst_n) begin
      mv = 0; mph = PH_UP; mhit = 0; mpc = 0;
    end else if (load) begin
      mv = (int'(load_value) > tp) ? tp : int'(load_value);
      mph = PH_UP; mhit = 0; mpc = 0;
    end else if (!enable) begin
      mhit = 0;
    end else if (restart) begin
      mv = 0; mph = PH_UP; mhit = 0; mpc = 0;
    end else begin
      mhit = 0;
      adv  = 1;
`ifdef PROG_COUNTER_PRESCALE_EN
      mpc = mpc + 1;
      adv = (mpc == PRESCALE);
      if (adv) mpc = 0;
`endif
      if (adv && mph == PH_UP) begin
        sum = mv + STEP;
        if (mode == 2'd1) begin
          if (mv >= tp) begin
            mhit = (mv > tp) || (tp == 0);
            mv   = 0;
          end else if (sum >= tp) begin
            mv = tp; mhit = 1;
          end else begin
            mv = sum;
          end
        end else if (sum >= tp) begin
          mv   = tp;
          mhit = 1;
          mph  = (mode == 2'd2) ? PH_DOWN : PH_DONE;
        end else begin
          mv = sum;
        end
      end else if (adv && mph == PH_DOWN) begin
        mv = (mv > STEP) ? mv - STEP : 0;
        if (mv == 0) mph = PH_UP;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit en, input bit ld, input int lv,
                       input int tp, input int md, input bit rs);
    exp_t e;
    @(negedge clk);
    rst_n      = r;
    enable     = en;
    load       = ld;
    load_value = WIDTH'(lv);
    top        = WIDTH'(tp);
    mode       = 2'(md);
    restart    = rs;
    model_step();
    e.value = mv;
    e.hit   = mhit;
    e.done  = (mph == PH_DONE);
    e.dir   = (mph == PH_DOWN);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input int tp, input int md);
    for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, tp, md, 0);
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    checks = checks + 1;
    if (act != exp_v) begin
      failures = failures + 1;
      $display("FAIL %s txn=%0d: got %0d expected %0d", name, txn, act, exp_v);
    end
  endtask

  // Monitor: the DUT presents a new output every cycle, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        txn = txn + 1;
        $display("txn %0d value=%0d hit=%0b done=%0b dir=%0b (exp %0d %0b %0b %0b)",
                 txn, value, hit_top, done, dir, e.value, e.hit, e.done, e.dir);
        check("value", int'(value), e.value);
        check("hit_top", int'(hit_top), int'(e.hit));
        check("done", int'(done), int'(e.done));
        check("dir", int'(dir), int'(e.dir));
      end
    end
  end

  initial begin
    int r_top;
    int r_mode;
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; load_value = '0;
    top = '0; mode = '0; restart = 1'b0;

    cycle(0, 0, 0, 0, 5, 0, 0);
    cycle(0, 1, 1, 9, 5, 0, 1);
    // HOLD to top, freeze in DONE, ignored restart while disabled, then restart.
    run(10, 5, 0);
    cycle(1, 0, 0, 0, 5, 0, 1);
    cycle(1, 1, 0, 0, 5, 0, 1);
    run(4, 5, 0);
    // WRAP and BOUNCE sequences.
    cycle(1, 1, 0, 0, 7, 1, 1);
    run(14, 7, 1);
    cycle(1, 1, 0, 0, 8, 2, 1);
    run(20, 8, 2);
    // Load above top clamps; simultaneous load and reset.
    cycle(1, 1, 0, 0, 20, 0, 1);
    run(3, 20, 0);
    cycle(1, 1, 1, 40, 20, 0, 0);
    run(4, 20, 0);
    cycle(0, 1, 1, 9, 20, 0, 0);
    // Top lowered under the count in WRAP.
    run(9, 40, 1);
    run(4, 2, 1);
    // Top of zero in each mode.
    cycle(1, 1, 0, 0, 0, 1, 1);
    run(5, 0, 1);
    run(5, 0, 2);
    run(3, 0, 0);
    // Saturation near the maximum representable value.
    cycle(1, 1, 1, 62, 63, 2, 0);
    run(6, 63, 2);
    // Enable toggling.
    cycle(1, 1, 0, 0, 40, 1, 1);
    for (int i = 0; i < 16; i++) cycle(1, (i % 3) != 1, 0, 0, 40, 1, 0);

    r_top  = 20;
    r_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19, 0) == 0) r_top = $urandom_range(63, 0);
      if ($urandom_range(9, 0) == 0) r_mode = $urandom_range(3, 0);
      cycle($urandom_range(63, 0) != 0,
            $urandom_range(3, 0) != 0,
            $urandom_range(15, 0) == 0,
            $urandom_range(63, 0),
            r_top, r_mode,
            $urandom_range(15, 0) == 0);
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
